seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 37 +++
 rtl/seg7_scan_decoder.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Patterns are {a,b,c,d,e,f,g} with a as the MSB, segments lit = 1.
package seg7_pkg;

  localparam logic [6:0] PAT_0     = 7'h7E;
  localparam logic [6:0] PAT_1     = 7'h30;
  localparam logic [6:0] PAT_2     = 7'h6D;
  localparam logic [6:0] PAT_3     = 7'h79;
  localparam logic [6:0] PAT_4     = 7'h33;
  localparam logic [6:0] PAT_5     = 7'h5B;
  localparam logic [6:0] PAT_6     = 7'h5F;
  localparam logic [6:0] PAT_7     = 7'h70;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h7B;
  localparam logic [6:0] PAT_A     = 7'h77;
  localparam logic [6:0] PAT_B     = 7'h1F;
  localparam logic [6:0] PAT_C     = 7'h4E;
  localparam logic [6:0] PAT_D     = 7'h3D;
  localparam logic [6:0] PAT_E     = 7'h4F;
  localparam logic [6:0] PAT_F     = 7'h47;
  localparam logic [6:0] PAT_DASH  = 7'h01;
  localparam logic [6:0] PAT_BLANK = 7'h00;

  typedef enum logic [1:0] {
    CLS_HEX,
    CLS_DASH,
    CLS_BLANK,
    CLS_ERR
  } seg_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_LOCKED
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from a lit-segment pattern to {class, nibble}.
// Zero latency, no flow control.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output seg_class_t cls,
  output logic [3:0] nibble
);

  always_comb begin
    cls    = CLS_HEX;
    nibble = 4'h0;
    case (pat)
      PAT_0:     nibble = 4'h0;
      PAT_1:     nibble = 4'h1;
      PAT_2:     nibble = 4'h2;
      PAT_3:     nibble = 4'h3;
      PAT_4:     nibble = 4'h4;
      PAT_5:     nibble = 4'h5;
      PAT_6:     nibble = 4'h6;
      PAT_7:     nibble = 4'h7;
      PAT_8:     nibble = 4'h8;
      PAT_9:     nibble = 4'h9;
      PAT_A:     nibble = 4'hA;
      PAT_B:     nibble = 4'hB;
      PAT_C:     nibble = 4'hC;
      PAT_D:     nibble = 4'hD;
      PAT_E:     nibble = 4'hE;
      PAT_F:     nibble = 4'hF;
      PAT_DASH:  cls = CLS_DASH;
      PAT_BLANK: cls = CLS_BLANK;
      default:   cls = CLS_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit values from a multiplexed 7-seg scan after STABLE identical samples.
// Latency STABLE+1 enabled cycles to commit; sample_en low freezes sampling and the FSM.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG    = 8,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 65535,
  localparam int IDXW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           seg_n,
  input  logic [NDIG-1:0]      an_n,
  input  logic                 sample_en,
  output logic [4*NDIG-1:0]    digit_val,
  output logic [NDIG-1:0]      digit_vld,
  output logic [NDIG-1:0]      digit_dash,
  output logic [NDIG-1:0]      digit_err,
  output logic [NDIG-1:0]      digit_dp,
  output logic                 upd,
  output logic [IDXW-1:0]      upd_idx
);

  localparam int          AGEW       = $clog2(TIMEOUT + 1);
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(TIMEOUT);
  localparam logic [3:0]  STABLE_CNT = 4'(STABLE);

  function automatic logic [IDXW-1:0] low_idx(input logic [NDIG-1:0] a);
    low_idx = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (!a[i]) low_idx = IDXW'(i);
    end
  endfunction

  logic [7:0]      seg_q, seg_p;
  logic [NDIG-1:0] an_q, an_p;
  scan_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            commit;
  logic            sel_ok, same;
  logic [IDXW-1:0] sel_idx, lock_idx;
  seg_class_t      cls;
  logic [3:0]      nibble;
  logic [AGEW-1:0] age_q [NDIG];

  seg7_pattern_decode u_decode (
    .pat    (~seg_q[7:1]),
    .cls    (cls),
    .nibble (nibble)
  );

  assign sel_ok   = $onehot(~an_q);
  assign same     = (seg_q == seg_p) && (an_q == an_p);
  assign sel_idx  = low_idx(an_q);
  assign lock_idx = low_idx(an_p);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (sample_en) begin
      if (!sel_ok) begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end else if (!same || state_q == ST_IDLE) begin
        state_d = ST_TRACK;
        cnt_d   = 4'd1;
      end else if (state_q == ST_TRACK) begin
        if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        if (cnt_d == STABLE_CNT) begin
          commit  = 1'b1;
          state_d = ST_LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      seg_p   <= '0;
      an_q    <= '0;
      an_p    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
    end else if (sample_en) begin
      seg_q   <= seg_n;
      an_q    <= an_n;
      seg_p   <= seg_q;
      an_p    <= an_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upd     <= commit;
      if (commit) upd_idx <= sel_idx;
    end else begin
      upd <= 1'b0;
    end
  end

  // A commit outranks the age timeout; val is kept across timeouts and non-hex commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val  <= '0;
      digit_vld  <= '0;
      digit_dash <= '0;
      digit_err  <= '0;
      digit_dp   <= '0;
      for (int i = 0; i < NDIG; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (commit && sel_idx == IDXW'(i)) begin
          age_q[i] <= '0;
          case (cls)
            CLS_HEX: begin
              digit_val[4*i +: 4] <= nibble;
              digit_vld[i]        <= 1'b1;
              digit_dash[i]       <= 1'b0;
              digit_err[i]        <= 1'b0;
              digit_dp[i]         <= ~seg_q[0];
            end
            CLS_DASH: begin
              digit_vld[i]  <= 1'b0;
              digit_dash[i] <= 1'b1;
              digit_err[i]  <= 1'b0;
            end
            CLS_BLANK: begin
              digit_vld[i]  <= 1'b0;
              digit_dash[i] <= 1'b0;
              digit_err[i]  <= 1'b0;
            end
            default: begin
              digit_vld[i]  <= 1'b0;
              digit_dash[i] <= 1'b0;
              digit_err[i]  <= 1'b1;
            end
          endcase
        end else begin
          if (state_q == ST_LOCKED && lock_idx == IDXW'(i)) age_q[i] <= '0;
          else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
          if (age_q[i] == AGE_MAX) begin
            digit_vld[i]  <= 1'b0;
            digit_dash[i] <= 1'b0;
            digit_err[i]  <= 1'b0;
            digit_dp[i]   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus queues expected commits, a negedge monitor checks each upd pulse.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int NDIG    = 8;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT     = STABLE + 1;

  logic              clk;
  logic              rst_n;
  logic [7:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic              sample_en;
  logic [4*NDIG-1:0] digit_val;
  logic [NDIG-1:0]   digit_vld, digit_dash, digit_err, digit_dp;
  logic              upd;
  logic [2:0]        upd_idx;

  typedef struct {
    int         idx;
    logic [3:0] val;
    logic       vld;
    logic       dash;
    logic       err;
    logic       dp;
    logic       chk_dp;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .sample_en  (sample_en),
    .digit_val  (digit_val),
    .digit_vld  (digit_vld),
    .digit_dash (digit_dash),
    .digit_err  (digit_err),
    .digit_dp   (digit_dp),
    .upd        (upd),
    .upd_idx    (upd_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] enc(input logic [6:0] pat, input logic dp);
    return ~{pat, dp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] s, input logic [NDIG-1:0] a, input int n);
    seg_n = s;
    an_n  = a;
    tick(n);
  endtask

  task automatic expect_upd(input int idx, input logic [3:0] val, input logic vld,
                            input logic dash, input logic err, input logic dp,
                            input logic chk_dp, input int lag);
    exp_t e;
    e.idx = idx; e.val = val; e.vld = vld; e.dash = dash; e.err = err;
    e.dp = dp; e.chk_dp = chk_dp; e.due = cyc + lag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && upd) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_upd: got upd_idx %0d at cycle %0d, expected no update", upd_idx, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("upd_idx", 32'(upd_idx), 32'(e.idx));
        check("upd_cycle", 32'(cyc), 32'(e.due));
        check("val", 32'(digit_val[4*e.idx +: 4]), 32'(e.val));
        check("vld", 32'(digit_vld[e.idx]), 32'(e.vld));
        check("dash", 32'(digit_dash[e.idx]), 32'(e.dash));
        check("err", 32'(digit_err[e.idx]), 32'(e.err));
        if (e.chk_dp) check("dp", 32'(digit_dp[e.idx]), 32'(e.dp));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_val"}, digit_val, 32'h0);
    check({tag, "_vld"}, 32'(digit_vld), 32'h0);
    check({tag, "_dash"}, 32'(digit_dash), 32'h0);
    check({tag, "_err"}, 32'(digit_err), 32'h0);
    check({tag, "_dp"}, 32'(digit_dp), 32'h0);
    check({tag, "_upd"}, 32'(upd), 32'h0);
    check({tag, "_upd_idx"}, 32'(upd_idx), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b1;
    seg_n     = 8'hFF;
    an_n      = '1;
    tick(2);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Digit 0 shows '0', held one cycle past the commit.
    expect_upd(0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT);
    present(enc(PAT_0, 1'b0), 8'hFE, LAT + 1);

    // Digit 5 shows 'A' with the decimal point lit.
    expect_upd(5, 4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, LAT);
    present(enc(PAT_A, 1'b1), 8'hDF, LAT);

    // Digit 2: a short-lived '7' never commits, the following '8' does.
    present(enc(PAT_7, 1'b0), 8'hFB, 3);
    expect_upd(2, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT);
    present(enc(PAT_8, 1'b0), 8'hFB, 4);

    // Two digits selected at once: no commit, FSM parked in IDLE.
    present(enc(PAT_0, 1'b0), 8'hFC, 10);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Dash on digit 7.
    expect_upd(7, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LAT);
    present(8'hFD, 8'h7F, LAT);

    // Digit 3: '5', then an unknown pattern keeps val and flags err.
    expect_upd(3, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT);
    present(enc(PAT_5, 1'b0), 8'hF7, LAT);
    expect_upd(3, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LAT);
    present(8'hAA, 8'hF7, LAT);

    // Scan moves to digit 1; digit 3 ages out while digit 1 stays refreshed.
    expect_upd(1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT);
    present(enc(PAT_1, 1'b0), 8'hFD, 10);
    check("err3_before_timeout", 32'(digit_err[3]), 32'h1);
    tick(20);
    check("err3_after_timeout", 32'(digit_err[3]), 32'h0);
    check("val3_retained", 32'(digit_val[15:12]), 32'h5);
    check("vld1_refreshed", 32'(digit_vld[1]), 32'h1);

    // Blank on digit 1 clears its flags but keeps val.
    expect_upd(1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LAT);
    present(enc(PAT_BLANK, 1'b0), 8'hFD, LAT);

    // Reset in the middle of tracking '3' on digit 4.
    check("val3_before_reset", 32'(digit_val[15:12]), 32'h5);
    present(enc(PAT_3, 1'b0), 8'hEF, 4);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick(1);
    rst_n = 1'b1;
    expect_upd(4, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT);
    tick(LAT + 1);

    // 'E' with dp on digit 6, interrupted by five frozen cycles of garbage input.
    expect_upd(6, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, LAT + 5);
    present(enc(PAT_E, 1'b1), 8'hBF, 2);
    sample_en = 1'b0;
    present(enc(PAT_8, 1'b0), 8'hFE, 5);
    sample_en = 1'b1;
    present(enc(PAT_E, 1'b1), 8'hBF, 3);
    present(8'hFF, '1, 4);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
